k_bit_feeder: RTL and testbench

Supplies the scalar k, one bit at a time, to the Montgomery-ladder scalar multiplier over its k_req/k_val/k_bit/k_last handshake. The controller writes k word by word, then pulses start. The block locates the most-significant 1 of k, which the ladder consumes implicitly through its R_0 = P, R_1 = 2P initialisation. It then serves the remaining bits MSB-first and flags the final bit with k_last. It sits between the ECM stage controller / scalar SRAM and the ladder.

---
 rtl/k_bit_feeder.sv | 101 ++++++++++
 tb/tb_k_bit_feeder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/k_bit_feeder.sv
// Scalar bit source for the Montgomery ladder: finds the leading 1 of k (consumed
// implicitly by the ladder's R0=P, R1=2P start) and serves the remaining bits MSB-first.
module k_bit_feeder #(
  parameter int NUM_WIDTH  = 256,
  parameter int WORD_WIDTH = 32,
  localparam int NUM_WORDS = NUM_WIDTH / WORD_WIDTH,
  localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int PW        = $clog2(NUM_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_we,
  input  logic [AW-1:0]         load_addr,
  input  logic [WORD_WIDTH-1:0] load_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  ready,
  output logic                  k_invalid,
  input  logic                  k_req,
  output logic                  k_val,
  output logic                  k_bit,
  output logic                  k_last
);

  typedef enum logic [2:0] {IDLE, SCAN, SERVE, DONE, ERR} state_t;

  state_t               state;
  logic [NUM_WIDTH-1:0] k_reg;
  logic [PW-1:0]        ptr;
  logic                 load_ok;

  // The scalar is frozen while a run is reading it.
  assign load_ok = (state == IDLE) || (state == DONE) || (state == ERR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_reg     <= '0;
      ptr       <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      k_invalid <= 1'b0;
      k_val     <= 1'b0;
      k_bit     <= 1'b0;
      k_last    <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (load_we && load_ok)
        k_reg[int'(load_addr)*WORD_WIDTH +: WORD_WIDTH] <= load_data;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            ptr       <= PW'(NUM_WIDTH - 1);
            k_invalid <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SCAN: begin
          // Leading 1 at index 0, or no 1 at all, means k < 2.
          if (ptr == '0) begin
            if (k_reg[ptr]) begin
              state     <= ERR;
              k_invalid <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state     <= ERR;
              k_invalid <= 1'b1;
              busy      <= 1'b0;
            end
          end else if (k_reg[ptr]) begin
            state <= SERVE;
            ptr   <= ptr - 1'b1;
          end else begin
            ptr <= ptr - 1'b1;
          end
        end
        SERVE: begin
          if (k_val) begin
            k_val <= 1'b0;
            if (k_last) begin
              state <= DONE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end else begin
              ptr <= ptr - 1'b1;
            end
          end else if (k_req) begin
            k_val  <= 1'b1;
            k_bit  <= k_reg[ptr];
            k_last <= (ptr == '0);
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k_bit_feeder.sv
// Directed bench for k_bit_feeder at NUM_WIDTH=16, WORD_WIDTH=8.
module tb_k_bit_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_we = 1'b0;
  logic [0:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       start = 1'b0;
  logic       k_req = 1'b0;
  logic       busy, ready, k_invalid, k_val, k_bit, k_last;

  int n_vec = 0;
  int n_err = 0;

  k_bit_feeder #(.NUM_WIDTH(16), .WORD_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .busy(busy), .ready(ready),
    .k_invalid(k_invalid), .k_req(k_req), .k_val(k_val), .k_bit(k_bit), .k_last(k_last)
  );

  always #5 clk = ~clk;

  task automatic load_word(input logic a, input logic [7:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  task automatic load_k(input logic [15:0] k);
    load_word(1'b0, k[7:0]);
    load_word(1'b1, k[15:8]);
  endtask

  // Starts a run and acts as the ladder until ready or the error exit.
  task automatic run(input int gap, input bit poke, input int load_c,
                     output logic [31:0] bits, output int n, output int last_cnt,
                     output int last_idx, output int first_c, output int ready_gap,
                     output bit viol, output bit tout);
    int last_kv_c, cnt;
    bit prev_kv;
    bits = '0; n = 0; last_cnt = 0; last_idx = -1; first_c = -1; ready_gap = -1;
    viol = 0; tout = 1; last_kv_c = -100; prev_kv = 0; cnt = 0;
    start = 1'b0; k_req = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; k_req = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      start = poke && (c % 3 == 0);
      load_we = (c == load_c); load_addr = 1'b1; load_data = 8'hFF;
      if (k_val) begin
        if (!k_req || prev_kv || !busy) viol = 1;
        bits[n] = k_bit;
        if (k_last) begin last_cnt++; last_idx = n; end
        if (first_c < 0) first_c = c;
        last_kv_c = c;
        n++;
      end
      if (ready) begin
        ready_gap = c - last_kv_c;
        if (busy) viol = 1;
        tout = 0;
        break;
      end
      if (k_invalid && !busy) begin tout = 0; break; end
      prev_kv = k_val;
      if (gap > 0) begin
        if (k_val) begin k_req = 1'b0; cnt = gap; end
        else if (cnt > 0) begin cnt--; if (cnt == 0) k_req = 1'b1; end
      end
    end
    start = 1'b0; load_we = 1'b0; k_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({k_val, k_bit, k_last, ready, k_invalid, busy} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs got %b want 000000", {k_val, k_bit, k_last, ready, k_invalid, busy});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] b; int n, lc, li, fc, rg; bit v, t;
    load_k(16'h000B);
    run(0, 0, 0, b, n, lc, li, fc, rg, v, t);
    n_vec++; if (t !== 0 || n !== 3) begin n_err++; $display("FAIL basic_count got %0d (timeout %0d) want 3", n, t); end
    n_vec++; if (b[2:0] !== 3'b110) begin n_err++; $display("FAIL basic_bits got %b want 110", b[2:0]); end
    n_vec++; if (lc !== 1 || li !== 2) begin n_err++; $display("FAIL basic_last got cnt %0d idx %0d want 1/2", lc, li); end
    n_vec++; if (fc !== 15) begin n_err++; $display("FAIL basic_latency got %0d want 15", fc); end
    n_vec++; if (rg !== 1) begin n_err++; $display("FAIL basic_ready_gap got %0d want 1", rg); end
    n_vec++; if (v !== 0 || k_invalid !== 1'b0) begin n_err++; $display("FAIL basic_proto got viol %0d inv %0b want 0/0", v, k_invalid); end
  endtask

  task automatic test_ladder;
    logic [31:0] b; int n, lc, li, fc, rg; bit v, t;
    load_k(16'h8001);
    run(5, 0, 0, b, n, lc, li, fc, rg, v, t);
    n_vec++; if (t !== 0 || n !== 15) begin n_err++; $display("FAIL ladder_count got %0d (timeout %0d) want 15", n, t); end
    n_vec++; if (b[14:0] !== 15'h4000) begin n_err++; $display("FAIL ladder_bits got %h want 4000", b[14:0]); end
    n_vec++; if (lc !== 1 || li !== 14) begin n_err++; $display("FAIL ladder_last got cnt %0d idx %0d want 1/14", lc, li); end
    n_vec++; if (v !== 0) begin n_err++; $display("FAIL ladder_handshake got viol %0d want 0", v); end
    n_vec++; if (fc !== 3) begin n_err++; $display("FAIL ladder_latency got %0d want 3", fc); end
  endtask

  task automatic test_invalid;
    logic [31:0] b; int n, lc, li, fc, rg; bit v, t;
    load_k(16'h0001);
    run(0, 0, 0, b, n, lc, li, fc, rg, v, t);
    n_vec++; if (t !== 0 || n !== 0 || k_invalid !== 1'b1 || busy !== 1'b0)
      begin n_err++; $display("FAIL inv_k1 got n %0d inv %0b busy %0b to %0d want 0/1/0/0", n, k_invalid, busy, t); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (k_invalid !== 1'b1) begin n_err++; $display("FAIL inv_sticky got %0b want 1", k_invalid); end
    load_k(16'h0000);
    run(0, 0, 0, b, n, lc, li, fc, rg, v, t);
    n_vec++; if (t !== 0 || n !== 0 || k_invalid !== 1'b1)
      begin n_err++; $display("FAIL inv_k0 got n %0d inv %0b to %0d want 0/1/0", n, k_invalid, t); end
    load_k(16'h000B);
    run(0, 0, 0, b, n, lc, li, fc, rg, v, t);
    n_vec++; if (k_invalid !== 1'b0 || n !== 3)
      begin n_err++; $display("FAIL inv_clear got inv %0b n %0d want 0/3", k_invalid, n); end
  endtask

  task automatic test_load_during_serve;
    logic [31:0] b; int n, lc, li, fc, rg; bit v, t;
    load_k(16'h000B);
    run(0, 0, 16, b, n, lc, li, fc, rg, v, t);
    n_vec++; if (n !== 3 || b[2:0] !== 3'b110) begin n_err++; $display("FAIL wr_serve got n %0d bits %b want 3/110", n, b[2:0]); end
    run(0, 0, 0, b, n, lc, li, fc, rg, v, t);
    n_vec++; if (n !== 3 || b[2:0] !== 3'b110 || li !== 2)
      begin n_err++; $display("FAIL wr_replay got n %0d bits %b last %0d want 3/110/2", n, b[2:0], li); end
  endtask

  task automatic test_start_during_run;
    logic [31:0] b; int n, lc, li, fc, rg; bit v, t;
    run(0, 1, 0, b, n, lc, li, fc, rg, v, t);
    n_vec++; if (n !== 3 || b[2:0] !== 3'b110 || lc !== 1 || fc !== 15)
      begin n_err++; $display("FAIL start_ignored got n %0d bits %b last %0d first %0d want 3/110/1/15", n, b[2:0], lc, fc); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] b; int n, lc, li, fc, rg, extra; bit v, t, seen;
    load_k(16'h000B);
    @(posedge clk); #1;
    start = 1'b1; k_req = 1'b1; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k_val) seen = 1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL rstmid_first_kval got none want 1"); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_vec++; if ({k_val, k_bit, k_last, ready, k_invalid, busy} !== 6'b0)
      begin n_err++; $display("FAIL rstmid_outputs got %b want 000000", {k_val, k_bit, k_last, ready, k_invalid, busy}); end
    extra = 0;
    repeat (10) begin @(posedge clk); #1; if (k_val) extra++; end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL rstmid_no_kval got %0d want 0", extra); end
    k_req = 1'b0;
    run(0, 0, 0, b, n, lc, li, fc, rg, v, t);
    n_vec++; if (t !== 0 || n !== 0 || k_invalid !== 1'b1)
      begin n_err++; $display("FAIL rstmid_k_cleared got n %0d inv %0b to %0d want 0/1/0", n, k_invalid, t); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ladder;
    test_invalid;
    test_load_during_serve;
    test_start_during_run;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
